// File: rtl/io_mmio_bridge.sv
// rtl/io_mmio_bridge.sv - memory-mapped IO bridge: command latch, status sync, sticky edge events, goal counter
module io_mmio_bridge #(
  parameter int unsigned IO_BASE     = 4096,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        io_sel,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [31:0] reg_24,
  output logic        cmd_strobe,
  input  logic [31:0] reg_25
);

  localparam logic [31:0] BASE = 32'(IO_BASE);

  logic [31:0] offset;
  logic        store;
  logic        load;
  logic        sel_cmd;
  logic        sel_status;
  logic        sel_events;
  logic        sel_goals;

  assign io_sel     = (addr >= BASE);
  assign offset     = addr - BASE;
  assign store      = we && io_sel;
  // A store wins over a simultaneous load; the load is simply dropped.
  assign load       = re && !we && io_sel;
  assign sel_cmd    = (offset == 32'd0);
  assign sel_status = (offset == 32'd1);
  assign sel_events = (offset == 32'd2);
  assign sel_goals  = (offset == 32'd3);

  logic unused_status_hi;
  assign unused_status_hi = ^reg_25[31:6];

  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] sync;
  logic [5:0] prev;
  logic [5:0] rise;
  logic       limit_rise;
  logic       beam_rise;
  logic       goalie_rise;
  logic [15:0] goals;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 6'd0;
      prev <= 6'd0;
    end else begin
      sync_q[0] <= reg_25[5:0];
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
    end
  end

  logic clr_events;
  logic clr_goals;

  assign clr_events = load && sel_events;
  assign clr_goals  = store && sel_goals;

  // Flags are set from the combinational rise so set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      limit_rise  <= 1'b0;
      beam_rise   <= 1'b0;
      goalie_rise <= 1'b0;
    end else begin
      limit_rise  <= (limit_rise  && !clr_events) || rise[5];
      beam_rise   <= (beam_rise   && !clr_events) || rise[4];
      goalie_rise <= (goalie_rise && !clr_events) || rise[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      goals <= 16'd0;
    end else if (rise[4]) begin
      if (clr_goals) goals <= 16'd1;
      else if (goals != 16'hFFFF) goals <= goals + 16'd1;
    end else if (clr_goals) begin
      goals <= 16'd0;
    end
  end

  logic [31:0] load_data;

  always_comb begin
    load_data = 32'd0;
    if (sel_cmd)         load_data = reg_24;
    else if (sel_status) load_data = {26'd0, sync};
    else if (sel_events) load_data = {29'd0, goalie_rise, beam_rise, limit_rise};
    else if (sel_goals)  load_data = {16'd0, goals};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_24      <= 32'd0;
      cmd_strobe  <= 1'b0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
    end else begin
      cmd_strobe  <= store && sel_cmd;
      if (store && sel_cmd) reg_24 <= wdata;
      rdata_valid <= load;
      if (load) rdata <= load_data;
    end
  end

endmodule

// File: tb/tb_io_mmio_bridge.sv
// tb/tb_io_mmio_bridge.sv - randomized self-checking bench for io_mmio_bridge
module tb_io_mmio_bridge;

  localparam int unsigned IO_BASE = 4096;
  localparam int unsigned S       = 2;
  localparam logic [31:0] BASE    = 32'(IO_BASE);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        io_sel;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [31:0] reg_24;
  logic        cmd_strobe;
  logic [31:0] reg_25 = 32'd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_cmd = 32'd0;
  logic [5:0]  m_status = 6'd0;
  logic [2:0]  m_flags = 3'd0;
  logic [15:0] m_goals = 16'd0;

  logic [31:0] c_rdata;
  logic        c_valid;
  logic [31:0] c_reg24;
  logic        c_strobe;

  io_mmio_bridge #(.IO_BASE(IO_BASE), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .io_sel(io_sel), .rdata(rdata), .rdata_valid(rdata_valid),
    .reg_24(reg_24), .cmd_strobe(cmd_strobe), .reg_25(reg_25)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk); #1;
    c_rdata = rdata; c_valid = rdata_valid; c_reg24 = reg_24; c_strobe = cmd_strobe;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic model_status(input logic [5:0] v);
    logic [5:0] r;
    r = v & ~m_status;
    m_flags = m_flags | {r[0], r[4], r[5]};
    if (r[4] && m_goals != 16'hFFFF) m_goals = m_goals + 16'd1;
    m_status = v;
    reg_25 = {26'($urandom), v};
  endtask

  task automatic expect_load(input int off, output logic [31:0] exp);
    case (off)
      0: exp = m_cmd;
      1: exp = {26'd0, m_status};
      2: begin exp = {29'd0, m_flags}; m_flags = 3'd0; end
      3: exp = {16'd0, m_goals};
      default: exp = 32'd0;
    endcase
  endtask

  task automatic test_reset;
    we = 1'b1; re = 1'b0; addr = BASE; wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (reg_24 !== 32'd0 || cmd_strobe !== 1'b0) begin
        errors++; $display("FAIL reset_hold: reg_24=%h strobe=%b expected 0/0", reg_24, cmd_strobe);
      end
      checks++;
      if (rdata !== 32'd0 || rdata_valid !== 1'b0) begin
        errors++; $display("FAIL reset_rdata: rdata=%h valid=%b expected 0/0", rdata, rdata_valid);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b1, 1'b0, BASE, 32'h1234);
    m_cmd = 32'h1234;
    checks++;
    if (c_reg24 !== 32'h1234 || c_strobe !== 1'b1) begin
      errors++; $display("FAIL reset_release_store: reg_24=%h strobe=%b expected 00001234/1", c_reg24, c_strobe);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_strobe !== 1'b0 || reg_24 !== 32'h1234) begin
      errors++; $display("FAIL strobe_one_cycle: strobe=%b reg_24=%h expected 0/00001234", cmd_strobe, reg_24);
    end
    @(negedge clk);
  endtask

  task automatic test_cmd_readback;
    access(1'b1, 1'b0, BASE, 32'd500);
    m_cmd = 32'd500;
    access(1'b0, 1'b1, BASE, 32'd0);
    checks++;
    if (c_valid !== 1'b1 || c_rdata !== 32'd500) begin
      errors++; $display("FAIL cmd_readback: rdata=%0d valid=%b expected 500/1", c_rdata, c_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rdata_valid !== 1'b0) begin
      errors++; $display("FAIL valid_one_cycle: valid=%b expected 0", rdata_valid);
    end
    @(negedge clk);
    access(1'b1, 1'b0, BASE + 32'd1, 32'hFFFF_FFFF);
    checks++;
    if (c_strobe !== 1'b0 || c_reg24 !== m_cmd) begin
      errors++; $display("FAIL status_store_ignored: strobe=%b reg_24=%h expected 0/%h", c_strobe, c_reg24, m_cmd);
    end
    access(1'b0, 1'b1, BASE + 32'd1, 32'd0);
    checks++;
    if (c_valid !== 1'b1 || c_rdata !== {26'd0, m_status}) begin
      errors++; $display("FAIL status_unchanged: rdata=%h valid=%b expected %h/1", c_rdata, c_valid, {26'd0, m_status});
    end
  endtask

  task automatic test_sync_latency;
    int first;
    logic [31:0] exp;
    first = -1;
    model_status(6'h30);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, 1'b1, BASE + 32'd1, 32'd0);
      if (first < 0 && c_valid === 1'b1 && c_rdata === 32'h30) first = i;
    end
    checks++;
    if (first != int'(S)) begin
      errors++; $display("FAIL sync_latency: first visible load index=%0d expected %0d", first, S);
    end
    expect_load(2, exp);
    access(1'b0, 1'b1, BASE + 32'd2, 32'd0);
    checks++;
    if (c_rdata !== 32'h3 || exp !== 32'h3) begin
      errors++; $display("FAIL events_first: rdata=%h model=%h expected 00000003", c_rdata, exp);
    end
    expect_load(2, exp);
    access(1'b0, 1'b1, BASE + 32'd2, 32'd0);
    checks++;
    if (c_rdata !== exp) begin
      errors++; $display("FAIL events_cleared: rdata=%h expected %h", c_rdata, exp);
    end
  endtask

  task automatic test_set_beats_clear;
    model_status(m_status | 6'h01);
    tick(int'(S));
    access(1'b0, 1'b1, BASE + 32'd2, 32'd0);
    checks++;
    if (c_valid !== 1'b1 || c_rdata !== 32'd0) begin
      errors++; $display("FAIL set_vs_clear_pre: rdata=%h valid=%b expected 00000000/1", c_rdata, c_valid);
    end
    access(1'b0, 1'b1, BASE + 32'd2, 32'd0);
    m_flags = 3'd0;
    checks++;
    if (c_rdata !== 32'h4) begin
      errors++; $display("FAIL set_vs_clear_post: rdata=%h expected 00000004", c_rdata);
    end
  endtask

  task automatic test_goals;
    logic [31:0] exp;
    access(1'b1, 1'b0, BASE + 32'd3, 32'd99);
    m_goals = 16'd0;
    for (int i = 0; i < 5; i++) begin
      model_status(m_status & ~6'h10); tick(int'(S) + 1);
      model_status(m_status | 6'h10);  tick(int'(S) + 1);
    end
    access(1'b0, 1'b1, BASE + 32'd3, 32'd0);
    checks++;
    if (c_rdata !== 32'd5 || m_goals !== 16'd5) begin
      errors++; $display("FAIL goals_count: rdata=%0d model=%0d expected 5", c_rdata, m_goals);
    end
    access(1'b1, 1'b0, BASE + 32'd3, 32'd123);
    m_goals = 16'd0;
    access(1'b0, 1'b1, BASE + 32'd3, 32'd0);
    checks++;
    if (c_rdata !== 32'd0) begin
      errors++; $display("FAIL goals_clear: rdata=%0d expected 0", c_rdata);
    end
    force dut.goals = 16'hFFFF;
    tick(1);
    release dut.goals;
    m_goals = 16'hFFFF;
    model_status(m_status & ~6'h10); tick(int'(S) + 1);
    model_status(m_status | 6'h10);  tick(int'(S) + 1);
    access(1'b0, 1'b1, BASE + 32'd3, 32'd0);
    checks++;
    if (c_rdata !== 32'h0000_FFFF) begin
      errors++; $display("FAIL goals_saturate: rdata=%h expected 0000ffff", c_rdata);
    end
    expect_load(2, exp);
    access(1'b0, 1'b1, BASE + 32'd2, 32'd0);
    checks++;
    if (c_rdata !== exp) begin
      errors++; $display("FAIL goals_events: rdata=%h expected %h", c_rdata, exp);
    end
  endtask

  task automatic test_decode;
    addr = BASE - 32'd1; #1;
    checks++;
    if (io_sel !== 1'b0) begin errors++; $display("FAIL io_sel_below: io_sel=%b expected 0", io_sel); end
    addr = BASE; #1;
    checks++;
    if (io_sel !== 1'b1) begin errors++; $display("FAIL io_sel_base: io_sel=%b expected 1", io_sel); end
    addr = 32'hFFFF_FFFF; #1;
    checks++;
    if (io_sel !== 1'b1) begin errors++; $display("FAIL io_sel_top: io_sel=%b expected 1", io_sel); end
    @(negedge clk);
    access(1'b0, 1'b1, BASE - 32'd1, 32'd0);
    checks++;
    if (c_valid !== 1'b0) begin errors++; $display("FAIL load_below_base: valid=%b expected 0", c_valid); end
    access(1'b1, 1'b0, BASE - 32'd1, 32'hDEAD);
    checks++;
    if (c_strobe !== 1'b0 || c_reg24 !== m_cmd) begin
      errors++; $display("FAIL store_below_base: strobe=%b reg_24=%h expected 0/%h", c_strobe, c_reg24, m_cmd);
    end
    access(1'b0, 1'b1, BASE, 32'd0);
    access(1'b0, 1'b1, BASE + 32'd4, 32'd0);
    checks++;
    if (c_valid !== 1'b1 || c_rdata !== 32'd0) begin
      errors++; $display("FAIL load_out_of_map: rdata=%h valid=%b expected 00000000/1", c_rdata, c_valid);
    end
    access(1'b1, 1'b1, BASE, 32'd7);
    m_cmd = 32'd7;
    checks++;
    if (c_reg24 !== 32'd7 || c_strobe !== 1'b1 || c_valid !== 1'b0) begin
      errors++; $display("FAIL we_re_together: reg_24=%h strobe=%b valid=%b expected 00000007/1/0", c_reg24, c_strobe, c_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      access(1'b1, 1'b0, BASE, d);
      m_cmd = d;
      checks++;
      if (c_reg24 !== d || c_strobe !== 1'b1) begin
        errors++; $display("FAIL back_to_back_%0d: reg_24=%h strobe=%b expected %h/1", i, c_reg24, c_strobe, d);
      end
    end
  endtask

  task automatic test_random;
    int k;
    int off;
    logic [31:0] d;
    logic [31:0] exp;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      case (k)
        0, 1: begin
          access(1'b1, 1'b0, BASE, d);
          m_cmd = d;
          checks++;
          if (c_reg24 !== d || c_strobe !== 1'b1) begin
            errors++; $display("FAIL rnd_cmd_store: reg_24=%h strobe=%b expected %h/1", c_reg24, c_strobe, d);
          end
        end
        2: begin
          off = $urandom_range(1, 7);
          if (off == 3) off = 2;
          access(1'b1, 1'b0, BASE + 32'(off), d);
          checks++;
          if (c_strobe !== 1'b0 || c_reg24 !== m_cmd) begin
            errors++; $display("FAIL rnd_ignored_store: off=%0d strobe=%b reg_24=%h expected 0/%h", off, c_strobe, c_reg24, m_cmd);
          end
        end
        3: begin
          access(1'b1, 1'b0, BASE + 32'd3, d);
          m_goals = 16'd0;
        end
        4, 5, 6, 7: begin
          off = $urandom_range(0, 5);
          expect_load(off, exp);
          access(1'b0, 1'b1, BASE + 32'(off), 32'd0);
          checks++;
          if (c_valid !== 1'b1 || c_rdata !== exp) begin
            errors++; $display("FAIL rnd_load: off=%0d rdata=%h valid=%b expected %h/1", off, c_rdata, c_valid, exp);
          end
        end
        8: begin
          model_status(6'(d));
          tick(int'(S) + 1);
        end
        default: begin
          access(1'b0, 1'b1, 32'($urandom_range(0, IO_BASE - 1)), 32'd0);
          checks++;
          if (c_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_load_below: valid=%b expected 0", c_valid);
          end
        end
      endcase
    end
  endtask

  task automatic test_mid_reset;
    model_status(6'd0);
    tick(int'(S) + 1);
    reset_n = 1'b0;
    we = 1'b1; re = 1'b0; addr = BASE; wdata = 32'hA5A5;
    @(posedge clk); #1;
    checks++;
    if (reg_24 !== 32'd0 || cmd_strobe !== 1'b0) begin
      errors++; $display("FAIL mid_reset_store: reg_24=%h strobe=%b expected 0/0", reg_24, cmd_strobe);
    end
    @(negedge clk);
    we = 1'b0;
    reset_n = 1'b1;
    m_cmd = 32'd0; m_flags = 3'd0; m_goals = 16'd0;
    access(1'b0, 1'b1, BASE + 32'd3, 32'd0);
    checks++;
    if (c_rdata !== 32'd0 || c_valid !== 1'b1) begin
      errors++; $display("FAIL reset_goals: rdata=%h valid=%b expected 0/1", c_rdata, c_valid);
    end
    access(1'b0, 1'b1, BASE, 32'd0);
    checks++;
    if (c_rdata !== m_cmd) begin
      errors++; $display("FAIL reset_cmd: rdata=%h expected %h", c_rdata, m_cmd);
    end
  endtask

  initial begin
    test_reset;
    test_cmd_readback;
    test_sync_latency;
    test_set_beats_clear;
    test_goals;
    test_decode;
    test_back_to_back;
    test_random;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
